// File: rtl/hop_pkg.sv
// hop_pkg: shared sizing helpers and defaults for the hop chain array.
package hop_pkg;
  localparam int DEFAULT_DEPTH = 7;
  localparam int DEFAULT_LANES = 4;
  function automatic int tap_w(input int depth);
    return $clog2(depth + 1);
  endfunction
  // Out-of-range selects (0 or beyond the last stage) fall back to the last stage.
  function automatic int clamp_tap(input int sel, input int depth);
    return (sel == 0 || sel > depth) ? depth : sel;
  endfunction
endpackage

// File: rtl/hop_lane.sv
// hop_lane: one shift pipeline with stall, flush, output tap mux and occupancy count.
// Optional HOP_STAGE_CLR_EN adds per-stage synchronous clears.
module hop_lane import hop_pkg::*; #(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int DATA_W = 1,
  parameter int TAP_W  = tap_w(DEPTH)
) (
  input  logic              clock0,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              adv,
  input  logic              flush,
`ifdef HOP_STAGE_CLR_EN
  input  logic [DEPTH-1:0]  stage_clr,
`endif
  input  logic [TAP_W-1:0]  tap_sel,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic [TAP_W-1:0]  occupancy,
  output logic              lane_busy
);
  logic [DEPTH-1:0]             vld, vld_nx;
  logic [DEPTH-1:0][DATA_W-1:0] dat, dat_nx;
  logic [TAP_W-1:0]             occ_nx;
  int                           sel;
  always_comb begin
    vld_nx = adv ? {vld[DEPTH-2:0], in_valid} : vld;
    dat_nx = adv ? {dat[DEPTH-2:0], in_data} : dat;
`ifdef HOP_STAGE_CLR_EN
    vld_nx = vld_nx & ~stage_clr;
    for (int k = 0; k < DEPTH; k++) dat_nx[k] = stage_clr[k] ? '0 : dat_nx[k];
    occ_nx = TAP_W'($countones(vld_nx));
`else
    occ_nx = adv ? occupancy + TAP_W'(in_valid) - TAP_W'(vld[DEPTH-1]) : occupancy;
`endif
  end
  always_ff @(posedge clock0) begin
    if (!rst_n || flush) begin
      vld       <= '0;
      dat       <= '0;
      occupancy <= '0;
    end else begin
      vld       <= vld_nx;
      dat       <= dat_nx;
      occupancy <= occ_nx;
    end
  end
  // Output reads registered stages only, so there is no path from in_* to out_*.
  always_comb begin
    sel       = clamp_tap(int'(tap_sel), DEPTH) - 1;
    out_valid = 1'b0;
    out_data  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      out_valid = (k == sel) ? vld[k] : out_valid;
      out_data  = (k == sel) ? dat[k] : out_data;
    end
  end
  assign lane_busy = occupancy != '0;
endmodule

// File: rtl/hop_chain_array.sv
// hop_chain_array: NUM_LANES independent programmable-latency hop pipelines.
// Define HOP_STAGE_CLR_EN to add the per-stage stage_clr input.
module hop_chain_array import hop_pkg::*; #(
  parameter int NUM_LANES = DEFAULT_LANES,
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int DATA_W    = 1,
  parameter int TAP_W     = tap_w(DEPTH)
) (
  input  logic                        clock0,
  input  logic                        rst_n,
  input  logic [NUM_LANES-1:0]        in_valid,
  input  logic [NUM_LANES*DATA_W-1:0] in_data,
  input  logic [NUM_LANES-1:0]        adv,
  input  logic [NUM_LANES-1:0]        flush,
`ifdef HOP_STAGE_CLR_EN
  input  logic [NUM_LANES*DEPTH-1:0]  stage_clr,
`endif
  input  logic [NUM_LANES*TAP_W-1:0]  tap_sel,
  output logic [NUM_LANES-1:0]        out_valid,
  output logic [NUM_LANES*DATA_W-1:0] out_data,
  output logic [NUM_LANES*TAP_W-1:0]  occupancy,
  output logic [NUM_LANES-1:0]        lane_busy
);
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    hop_lane #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAP_W(TAP_W)) u_lane (
      .clock0    (clock0),
      .rst_n     (rst_n),
      .in_valid  (in_valid[l]),
      .in_data   (in_data[l*DATA_W +: DATA_W]),
      .adv       (adv[l]),
      .flush     (flush[l]),
`ifdef HOP_STAGE_CLR_EN
      .stage_clr (stage_clr[l*DEPTH +: DEPTH]),
`endif
      .tap_sel   (tap_sel[l*TAP_W +: TAP_W]),
      .out_valid (out_valid[l]),
      .out_data  (out_data[l*DATA_W +: DATA_W]),
      .occupancy (occupancy[l*TAP_W +: TAP_W]),
      .lane_busy (lane_busy[l])
    );
  end
endmodule

// File: tb/tb_hop_chain_array.sv
// tb_hop_chain_array: directed checks of reset, latency, stall, flush, tap select
// and (with HOP_STAGE_CLR_EN) stage clears.
module tb_hop_chain_array;
  localparam int L = 4, D = 7, W = 1, T = 3;
  logic clock0 = 1'b0;
  logic rst_n = 1'b0;
  logic [L-1:0]   in_valid = '0, in_data = '0, adv = '0, flush = '0;
  logic [L*T-1:0] tap_sel = {L{3'd7}};
  logic [L-1:0]   out_valid, out_data, lane_busy;
  logic [L*T-1:0] occupancy;
`ifdef HOP_STAGE_CLR_EN
  logic [L*D-1:0] stage_clr = '0;
`endif
  int checks = 0, errors = 0;
  logic [6:0] pat = 7'b1010001;

  hop_chain_array #(.NUM_LANES(L), .DEPTH(D), .DATA_W(W)) dut (
    .clock0(clock0), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .adv(adv), .flush(flush),
`ifdef HOP_STAGE_CLR_EN
    .stage_clr(stage_clr),
`endif
    .tap_sel(tap_sel), .out_valid(out_valid), .out_data(out_data),
    .occupancy(occupancy), .lane_busy(lane_busy));

  always #5 clock0 = ~clock0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock0);
    #2;
  endtask

  function automatic logic [T-1:0] occ(input int l);
    return occupancy[l*T +: T];
  endfunction

  initial begin
    in_valid = '1; in_data = '1; adv = '1;
    repeat (3) tick;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_occupancy", occupancy, 0);
    check("rst_busy", lane_busy, 0);
    in_valid = '0; in_data = '0;
    rst_n = 1'b1;
    tick;
    check("post_rst_occ", occupancy, 0);
    // latency: one word, tap 7
    in_valid[0] = 1'b1; in_data[0] = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick;
      in_valid[0] = 1'b0; in_data[0] = 1'b0;
      check($sformatf("lat_valid_c%0d", k), out_valid[0], k == 7);
      check($sformatf("lat_data_c%0d", k), out_data[0], k == 7);
      check($sformatf("lat_occ_c%0d", k), occ(0), k <= 7);
    end
    // stall for 3 cycles mid-chain
    in_valid[0] = 1'b1; in_data[0] = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      adv[0] = !(k >= 3 && k <= 5);
      tick;
      in_valid[0] = 1'b0; in_data[0] = 1'b0;
      check($sformatf("stall_valid_c%0d", k), out_valid[0], k == 10);
      check($sformatf("stall_occ_c%0d", k), occ(0), 1);
    end
    adv[0] = 1'b1;
    tick;
    check("stall_drain_occ", occ(0), 0);
    check("stall_drain_busy", lane_busy[0], 0);
    // flush: fill lane1 past full, occupancy saturates at DEPTH
    in_valid[1] = 1'b1; in_data[1] = 1'b1;
    repeat (7) tick;
    check("fill_occ", occ(1), 7);
    check("fill_busy", lane_busy[1], 1);
    repeat (2) tick;
    check("full_occ_steady", occ(1), 7);
    check("full_out_valid", out_valid[1], 1);
    flush[1] = 1'b1;
    tick;
    flush[1] = 1'b0; in_valid[1] = 1'b0; in_data[1] = 1'b0;
    check("flush_occ", occ(1), 0);
    check("flush_out_valid", out_valid[1], 0);
    check("flush_busy", lane_busy[1], 0);
    for (int k = 1; k <= 7; k++) begin
      tick;
      check($sformatf("flush_dropped_c%0d", k), out_valid[1], 0);
    end
    // tap switching on lane2: stage k holds pat[6-k]
    for (int k = 0; k < 7; k++) begin
      in_valid[2] = 1'b1; in_data[2] = pat[k];
      tick;
    end
    adv[2] = 1'b0; in_valid[2] = 1'b0;
    tap_sel[2*T +: T] = 3'd3; #1;
    check("tap3_data", out_data[2], pat[4]);
    check("tap3_valid", out_valid[2], 1);
    tap_sel[2*T +: T] = 3'd1; #1;
    check("tap1_data", out_data[2], pat[6]);
    tap_sel[2*T +: T] = 3'd2; #1;
    check("tap2_data", out_data[2], pat[5]);
    tap_sel[2*T +: T] = 3'd0; #1;
    check("tap0_data", out_data[2], pat[0]);
    tap_sel[2*T +: T] = 3'd5; #1;
    check("tap5_data", out_data[2], pat[2]);
    tap_sel[2*T +: T] = 3'd7; #1;
    check("tap7_data", out_data[2], pat[0]);
    tick;
    check("hold_occ", occ(2), 7);
    check("indep_lane3_occ", occ(3), 0);
    check("indep_lane3_valid", out_valid[3], 0);
`ifdef HOP_STAGE_CLR_EN
    in_valid[3] = 1'b1; in_data[3] = 1'b1;
    repeat (7) tick;
    check("clr_fill_occ", occ(3), 7);
    stage_clr[3*D+2] = 1'b1;
    tick;
    stage_clr = '0; adv[3] = 1'b0; in_valid[3] = 1'b0;
    check("clr_occ", occ(3), 6);
    tap_sel[3*T +: T] = 3'd3; #1;
    check("clr_bubble_valid", out_valid[3], 0);
    check("clr_bubble_data", out_data[3], 0);
    tap_sel[3*T +: T] = 3'd2; #1;
    check("clr_neighbour_valid", out_valid[3], 1);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
